// File: rtl/pipeline_fetch.sv
// Fetch stage of the pipelined RAT core: owns the PC, addresses the synchronous
// instruction BRAM and holds the fetch/decode latch feeding the decode stage.
module pipeline_fetch #(
   parameter int                     PC_WIDTH     = 10,
   parameter int                     INSTR_WIDTH  = 18,
   parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = 10'h000,
   parameter logic [PC_WIDTH-1:0]    INT_VECTOR   = 10'h3FF,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR    = 18'h00000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pc_reset,
   input  logic                   pc_load,
   input  logic [1:0]             pc_load_sel,
   input  logic                   pc_inc,
   input  logic [PC_WIDTH-1:0]    branch_target,
   input  logic [PC_WIDTH-1:0]    return_addr,
   input  logic                   imem_addr_mux,
   input  logic                   fetch_latch_stall,
   input  logic                   dec_nop,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   output logic [INSTR_WIDTH-1:0] dec_instr,
   output logic [PC_WIDTH-1:0]    dec_pc,
   output logic                   dec_valid
);

   typedef enum logic {
      BUBBLE = 1'b0,
      RUN    = 1'b1
   } fetch_state_t;

   fetch_state_t        state;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] fetch_pc_q;
   logic                fetch_valid;

   // Replay re-presents the address whose word is currently in flight.
   assign imem_addr   = imem_addr_mux ? fetch_pc_q : pc;
   assign fetch_valid = (state == RUN);

   always_ff @(posedge clk) begin
      if (reset || pc_reset) begin
         pc <= RESET_VECTOR;
      end else if (pc_load) begin
         case (pc_load_sel)
            2'd0:    pc <= branch_target;
            2'd1:    pc <= return_addr;
            2'd2:    pc <= INT_VECTOR;
            default: pc <= pc;
         endcase
      end else if (pc_inc) begin
         pc <= pc + PC_WIDTH'(1);
      end
   end

   // fetch_pc_q tags the BRAM word that shows up on imem_data next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_VECTOR;
      end else begin
         fetch_pc_q <= imem_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || pc_reset) begin
         state <= BUBBLE;
      end else begin
         state <= RUN;
      end
   end

   // Bubble insertion beats stall so control can squash a held wrong-path word.
   always_ff @(posedge clk) begin
      if (reset) begin
         dec_instr <= NOP_INSTR;
         dec_pc    <= '0;
         dec_valid <= 1'b0;
      end else if (dec_nop) begin
         dec_instr <= NOP_INSTR;
         dec_valid <= 1'b0;
      end else if (!fetch_latch_stall) begin
         dec_instr <= imem_data;
         dec_pc    <= fetch_pc_q;
         dec_valid <= fetch_valid;
      end
   end

endmodule
